usr_seq: RTL and testbench
==========================

Name: usr_seq

Overview:
- Sequencer and arbiter that shares one universal shift register (usr, bus index [0:WIDTH-1]) between two requesters.
- TX requester: parallel-to-serial. The block loads a word into the usr and shifts it out WIDTH bits.
- RX requester: serial-to-parallel. The block shifts WIDTH bits in from SER_IN and returns the word.
- The block drives all usr control inputs and sits directly beside the usr instance.

Parameters:
WIDTH, 4, usr word width / bits per transfer (≥2)

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  synchronous reset, active-high
TX_REQ  in  1  level request for a TX transfer
TX_DATA  in  [0:WIDTH-1]  word to transmit; sampled on the grant edge
TX_DIR  in  1  1 = shift right (bit WIDTH-1 first), 0 = shift left (bit 0 first); sampled on grant
TX_GNT  out  1  1-cycle pulse: TX accepted
TX_DONE  out  1  1-cycle pulse: last TX bit presented
RX_REQ  in  1  level request for an RX transfer
RX_DIR  in  1  direction for RX; sampled on grant
RX_GNT  out  1  1-cycle pulse: RX accepted
RX_DONE  out  1  1-cycle pulse: RX_DATA valid
RX_DATA  out  [0:WIDTH-1]  captured word; holds until next RX_DONE
SER_IN  in  1  external serial input line
SER_IN_SAMPLE  out  1  high in cycles whose closing edge shifts SER_IN into the usr
SER_OUT  out  1  external serial output (= USR_SERIAL_OUT)
SER_OUT_VALID  out  1  high while SER_OUT carries a TX bit
BUSY  out  1  state != IDLE
USR_RST_N  out  1  usr reset, active-low; = ~RST (combinational)
USR_CLR_N  out  1  usr clear, active-low; tied 1
USR_PARALLEL_MODE  out  1  1 = usr loads USR_PARALLEL_INPUT
USR_SHIFT_RIGHT  out  1  usr shift direction
USR_SERIAL_INPUT  out  1  usr serial in; = SER_IN in RX_SHIFT, else 0
USR_PARALLEL_INPUT  out  [0:WIDTH-1]  usr load word
USR_PARALLEL_OUT  in  [0:WIDTH-1]  usr parallel output
USR_SERIAL_OUT  in  1  usr registered serial output

Behaviour:
- usr constraints:
  - The usr has no hold mode; it shifts every cycle that PARALLEL_MODE=0.
  - Outside shift states the block holds PARALLEL_MODE=1 and PARALLEL_INPUT=hold register, which reloads the same word.
- Hold register:
  - Cleared to 0 on reset.
  - = TX_DATA on TX grant.
  - = USR_PARALLEL_OUT at the end of any shift phase.
- State machine: IDLE, TX_LOAD, TX_SHIFT, RX_SHIFT, RX_CAP. State and control outputs are registered.
- Reset (RST=1 at edge):
  - state=IDLE; bit counter=0; last-grant=RX; hold=0; RX_DATA=0.
  - All pulses/valids=0; USR_PARALLEL_MODE=1; USR_SHIFT_RIGHT=0.
  - Reset mid-transfer aborts it with no DONE pulse.
- IDLE:
  - Only TX_REQ → TX_LOAD. Only RX_REQ → RX_SHIFT.
  - Both asserted → round-robin: grant the side not in last-grant, then update last-grant. After reset, TX wins the first tie.
  - The GNT pulse is asserted in the first cycle of the new state.
  - Requests are ignored outside IDLE. A request still high after DONE is re-arbitrated in IDLE on the next cycle.
- TX_LOAD (1 cycle): PARALLEL_MODE=1, PARALLEL_INPUT=latched TX_DATA; the usr loads at the closing edge → TX_SHIFT.
- TX_SHIFT (WIDTH cycles):
  - PARALLEL_MODE=0, SHIFT_RIGHT=latched TX_DIR; the counter runs 0..WIDTH-1.
  - USR_SERIAL_OUT updates at each shift edge. SER_OUT_VALID is high for the WIDTH cycles following the first shift edge.
  - TX_DONE pulses in the last of those cycles, which is the first IDLE cycle; that cycle may also carry a new GNT.
- RX_SHIFT (WIDTH cycles):
  - PARALLEL_MODE=0, SHIFT_RIGHT=latched RX_DIR, SER_IN_SAMPLE=1.
  - Exits after the count reaches WIDTH-1 → RX_CAP.
- RX_CAP (1 cycle):
  - PARALLEL_MODE=1 with hold=USR_PARALLEL_OUT.
  - RX_DATA registered from USR_PARALLEL_OUT; RX_DONE pulses the cycle after → IDLE.
- Bit order:
  - Right shift: TX emits bit WIDTH-1 first; the first RX bit lands in bit WIDTH-1.
  - Left shift: TX emits bit 0 first; the first RX bit lands in bit 0.
- Counter is $clog2(WIDTH) bits wide. There is no wrap-around: the state exit occurs exactly at WIDTH-1.
- Throughput: TX = WIDTH+1 cycles grant-to-grant minimum; RX = WIDTH+2.

Test Plan:
- Reset: RST high 2 cycles mid-TX_SHIFT → BUSY=0, no TX_DONE, USR_PARALLEL_MODE=1, RX_DATA=0, USR_RST_N=0 during RST.
- TX right: WIDTH=4, TX_DATA=4'b1011, TX_DIR=1 → TX_GNT 1 cycle; SER_OUT under SER_OUT_VALID = 1,1,0,1; TX_DONE on 4th valid cycle.
- TX left: TX_DATA=4'b1011, TX_DIR=0 → SER_OUT = 1,0,1,1; usr content unchanged for 3 cycles of IDLE after (hold reload).
- RX right / left: SER_IN=1,1,0,0 on SER_IN_SAMPLE cycles → RX_DATA=4'b0011 with RX_DIR=1; 4'b1100 with RX_DIR=0; RX_DONE 1 cycle.
- Arbitration: TX_REQ and RX_REQ both held high from reset for 4 transfers → grant order TX, RX, TX, RX; no overlapping BUSY phases.
- Back-to-back: TX_REQ held high → next TX_GNT exactly WIDTH+1 cycles after previous TX_GNT; requests raised mid-transfer not granted until IDLE.

Source files
------------

// File: rtl/usr_seq.sv
// Sequencer/arbiter sharing one universal shift register between a TX (parallel-to-serial)
// and an RX (serial-to-parallel) requester. State and control outputs are registered.
module usr_seq #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TX_REQ,
  input  logic [0:WIDTH-1] TX_DATA,
  input  logic             TX_DIR,
  output logic             TX_GNT,
  output logic             TX_DONE,
  input  logic             RX_REQ,
  input  logic             RX_DIR,
  output logic             RX_GNT,
  output logic             RX_DONE,
  output logic [0:WIDTH-1] RX_DATA,
  input  logic             SER_IN,
  output logic             SER_IN_SAMPLE,
  output logic             SER_OUT,
  output logic             SER_OUT_VALID,
  output logic             BUSY,
  output logic             USR_RST_N,
  output logic             USR_CLR_N,
  output logic             USR_PARALLEL_MODE,
  output logic             USR_SHIFT_RIGHT,
  output logic             USR_SERIAL_INPUT,
  output logic [0:WIDTH-1] USR_PARALLEL_INPUT,
  input  logic [0:WIDTH-1] USR_PARALLEL_OUT,
  input  logic             USR_SERIAL_OUT
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    TX_LOAD,
    TX_SHIFT,
    RX_SHIFT,
    RX_CAP
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               last_tx;     // 1: most recent grant went to TX
  logic               dir_q;
  logic [0:WIDTH-1]   hold;
  logic               capture_q;   // first cycle after a shift phase: usr content is final
  logic               last_bit;
  logic               grant_tx;
  logic               grant_rx;
  logic               next_dir;
  logic               next_shift;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    grant_tx   = 1'b0;
    grant_rx   = 1'b0;
    last_bit   = (cnt == LAST);
    case (state)
      IDLE:     next_state = IDLE;
      TX_LOAD:  next_state = TX_SHIFT;
      TX_SHIFT: if (last_bit) next_state = IDLE;
      RX_SHIFT: if (last_bit) next_state = RX_CAP;
      RX_CAP:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    // TX also arbitrates on its last shift cycle so a new grant can share the TX_DONE cycle.
    if (state == IDLE || (state == TX_SHIFT && last_bit)) begin
      if (TX_REQ && RX_REQ) begin
        grant_tx = ~last_tx;
        grant_rx = last_tx;
      end else begin
        grant_tx = TX_REQ;
        grant_rx = RX_REQ;
      end
    end
    if (grant_tx)      next_state = TX_LOAD;
    else if (grant_rx) next_state = RX_SHIFT;
    next_dir   = grant_tx ? TX_DIR : (grant_rx ? RX_DIR : dir_q);
    next_shift = (next_state == TX_SHIFT) || (next_state == RX_SHIFT);
  end

  // NOTE: RST is sampled only at the clock edge, so it stays out of the sensitivity list;
  // every register here has a defined reset value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      cnt               <= '0;
      last_tx           <= 1'b0;
      dir_q             <= 1'b0;
      hold              <= '0;
      capture_q         <= 1'b0;
      RX_DATA           <= '0;
      TX_GNT            <= 1'b0;
      TX_DONE           <= 1'b0;
      RX_GNT            <= 1'b0;
      RX_DONE           <= 1'b0;
      SER_OUT_VALID     <= 1'b0;
      SER_IN_SAMPLE     <= 1'b0;
      BUSY              <= 1'b0;
      USR_PARALLEL_MODE <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state <= next_state;
      cnt   <= (state == next_state && (state == TX_SHIFT || state == RX_SHIFT))
               ? cnt + 1'b1 : '0;
      dir_q <= next_dir;
      if (grant_tx || grant_rx) last_tx <= grant_tx;

      if (grant_tx)       hold <= TX_DATA;
      else if (capture_q) hold <= USR_PARALLEL_OUT;
      capture_q <= last_bit && ((state == RX_SHIFT) ||
                                (state == TX_SHIFT && next_state == IDLE));

      if (state == RX_CAP) RX_DATA <= USR_PARALLEL_OUT;

      TX_GNT            <= grant_tx;
      RX_GNT            <= grant_rx;
      TX_DONE           <= (state == TX_SHIFT) && last_bit;
      RX_DONE           <= (state == RX_CAP);
      SER_OUT_VALID     <= (state == TX_SHIFT);
      SER_IN_SAMPLE     <= (next_state == RX_SHIFT);
      BUSY              <= (next_state != IDLE);
      USR_PARALLEL_MODE <= ~next_shift;
    end
  end

  // Right after a shift phase the usr reloads its own output, so its content does not move.
  assign USR_PARALLEL_INPUT = capture_q ? USR_PARALLEL_OUT : hold;
  assign USR_SHIFT_RIGHT    = dir_q;
  assign USR_SERIAL_INPUT   = (state == RX_SHIFT) && SER_IN;
  assign USR_RST_N          = ~RST;
  assign USR_CLR_N          = 1'b1;
  assign SER_OUT            = USR_SERIAL_OUT;

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: behavioural usr model, queue-based scoreboard fed by the stimulus,
// and a negedge monitor that checks serial bits, RX words, pulses and grant spacing.
module tb_usr_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_req, tx_dir, rx_req, rx_dir;
  logic [0:W-1] tx_data;
  logic         tx_gnt, tx_done, rx_gnt, rx_done;
  logic [0:W-1] rx_data;
  logic         ser_in = 1'b0;
  logic         ser_in_sample, ser_out, ser_out_valid, busy;
  logic         usr_rst_n, usr_clr_n, usr_pmode, usr_sr, usr_sin, usr_sout;
  logic [0:W-1] usr_pin, usr_q;

  always #5 clk = ~clk;

  usr_seq #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst),
    .TX_REQ(tx_req), .TX_DATA(tx_data), .TX_DIR(tx_dir), .TX_GNT(tx_gnt), .TX_DONE(tx_done),
    .RX_REQ(rx_req), .RX_DIR(rx_dir), .RX_GNT(rx_gnt), .RX_DONE(rx_done), .RX_DATA(rx_data),
    .SER_IN(ser_in), .SER_IN_SAMPLE(ser_in_sample), .SER_OUT(ser_out),
    .SER_OUT_VALID(ser_out_valid), .BUSY(busy),
    .USR_RST_N(usr_rst_n), .USR_CLR_N(usr_clr_n), .USR_PARALLEL_MODE(usr_pmode),
    .USR_SHIFT_RIGHT(usr_sr), .USR_SERIAL_INPUT(usr_sin), .USR_PARALLEL_INPUT(usr_pin),
    .USR_PARALLEL_OUT(usr_q), .USR_SERIAL_OUT(usr_sout)
  );

  // Universal shift register: load, or shift with a registered serial output.
  always @(posedge clk) begin
    if (!usr_rst_n || !usr_clr_n) begin
      usr_q    <= '0;
      usr_sout <= 1'b0;
    end else if (usr_pmode) begin
      usr_q <= usr_pin;
    end else if (usr_sr) begin
      usr_sout <= usr_q[W-1];
      usr_q    <= {usr_sin, usr_q[0:W-2]};
    end else begin
      usr_sout <= usr_q[0];
      usr_q    <= {usr_q[1:W-1], usr_sin};
    end
  end

  typedef struct packed { logic b; logic last; } txb_t;
  txb_t         tx_q[$];
  logic [0:W-1] rx_q[$];
  logic         rx_bits[$];

  int           checks = 0, errors = 0, cyc = 0;
  bit           mon_en = 1'b0, active = 1'b0;
  txb_t         mon_e;
  logic [0:W-1] d, b, got;
  bit           kind;
  int           n, gc_prev;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Expected serial stream: right shift emits bit W-1 first, left shift bit 0 first.
  task automatic push_tx(input logic [0:W-1] dv, input logic dir);
    for (int k = 0; k < W; k++) begin
      txb_t e;
      e.b    = dir ? dv[W-1-k] : dv[k];
      e.last = (k == W - 1);
      tx_q.push_back(e);
    end
  endtask

  // bv[k] is the k-th serial bit; right shift puts the first bit in W-1, left in 0.
  task automatic push_rx(input logic [0:W-1] bv, input logic dir);
    logic [0:W-1] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      rx_bits.push_back(bv[k]);
      if (dir) w[W-1-k] = bv[k];
      else     w[k]     = bv[k];
    end
    rx_q.push_back(w);
  endtask

  task automatic wait_gnt(input bit is_tx);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_tx ? tx_gnt : rx_gnt) return;
    end
    fail(is_tx ? "tx_gnt_timeout" : "rx_gnt_timeout");
  endtask

  task automatic wait_any(output bit k);
    k = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_gnt || rx_gnt) begin
        k = tx_gnt;
        return;
      end
    end
    fail("any_gnt_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && tx_q.size() == 0 && rx_q.size() == 0) return;
    end
    fail("idle_timeout");
  endtask

  task automatic wait_rx_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_done) return;
    end
    fail("rx_done_timeout");
  endtask

  task automatic do_tx(input logic [0:W-1] dv, input logic dir);
    tx_data = dv;
    tx_dir  = dir;
    push_tx(dv, dir);
    tx_req = 1'b1;
    wait_gnt(1'b1);
    tx_req = 1'b0;
  endtask

  task automatic do_rx(input logic [0:W-1] bv, input logic dir);
    rx_dir = dir;
    push_rx(bv, dir);
    rx_req = 1'b1;
    wait_gnt(1'b0);
    rx_req = 1'b0;
  endtask

  task automatic tx_collect(output logic [0:W-1] g, output int cnt);
    g   = '0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ser_out_valid && cnt < W) begin
        g[cnt] = ser_out;
        cnt++;
      end
      if (tx_done) return;
    end
    fail("tx_done_timeout");
  endtask

  // Serial input driver: presents queued RX bits in sample cycles, noise otherwise.
  always @(negedge clk) begin
    if (ser_in_sample === 1'b1 && !rst) begin
      if (rx_bits.size() == 0) begin
        fail("extra_ser_in_sample");
        ser_in = 1'b0;
      end else begin
        ser_in = rx_bits.pop_front();
      end
    end else begin
      ser_in = 1'($urandom);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (tx_done || rx_done) active = 1'b0;
      if (tx_gnt || rx_gnt) begin
        check("gnt_while_busy", 32'(active), 0);
        check("gnt_exclusive", 32'(tx_gnt & rx_gnt), 0);
        active = 1'b1;
      end
      if (ser_out_valid) begin
        if (tx_q.size() == 0) fail("unexpected_tx_bit");
        else begin
          mon_e = tx_q.pop_front();
          check("ser_out", 32'(ser_out), 32'(mon_e.b));
          check("tx_done_align", 32'(tx_done), 32'(mon_e.last));
        end
      end else if (tx_done) begin
        fail("tx_done_without_bit");
      end
      if (rx_done) begin
        if (rx_q.size() == 0) fail("unexpected_rx_done");
        else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_req = 1'b0; rx_req = 1'b0; tx_dir = 1'b0; rx_dir = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_pmode", 32'(usr_pmode), 1);
    check("rst_shift_right", 32'(usr_sr), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_usr_rst_n", 32'(usr_rst_n), 0);
    check("rst_usr_clr_n", 32'(usr_clr_n), 1);
    check("rst_pulses", 32'({tx_gnt, rx_gnt, tx_done, rx_done, ser_out_valid, ser_in_sample}), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("usr_rst_n_released", 32'(usr_rst_n), 1);

    // Both requests held from reset: grants alternate TX, RX, TX, RX.
    d = W'($urandom); tx_data = d; tx_dir = 1'b1; push_tx(d, 1'b1);
    push_rx(W'($urandom), 1'b0); push_rx(W'($urandom), 1'b1); rx_dir = 1'b0;
    n = 1;
    tx_req = 1'b1; rx_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_any(kind);
      check("arb_order", 32'(kind), 32'(i % 2 == 0));
      if (kind && n < 2) begin
        d = W'($urandom); tx_data = d; tx_dir = 1'b0; push_tx(d, 1'b0);
        n++;
      end else if (!kind) begin
        rx_dir = 1'b1;
      end
    end
    tx_req = 1'b0; rx_req = 1'b0;
    wait_idle();

    // Directed TX patterns; after the left transfer the usr must stay put (zero-filled).
    do_tx(4'b1011, 1'b1);
    tx_collect(got, n);
    check("tx_right_bits", 32'(got), 32'(4'b1101));
    check("tx_right_nbits", n, W);
    wait_idle();
    do_tx(4'b1011, 1'b0);
    tx_collect(got, n);
    check("tx_left_bits", 32'(got), 32'(4'b1011));
    check("tx_left_nbits", n, W);
    check("hold_at_done", 32'(usr_q), 0);
    repeat (3) begin
      @(negedge clk);
      check("hold_reload", 32'(usr_q), 0);
    end
    wait_idle();

    // Directed RX: serial 1,1,0,0.
    do_rx(4'b1100, 1'b1);
    wait_rx_done();
    check("rx_right_word", 32'(rx_data), 32'(4'b0011));
    @(negedge clk);
    check("rx_done_single", 32'(rx_done), 0);
    do_rx(4'b1100, 1'b0);
    wait_rx_done();
    check("rx_left_word", 32'(rx_data), 32'(4'b1100));
    wait_idle();

    // Back-to-back TX: grants exactly W+1 cycles apart.
    d = W'($urandom); tx_data = d; tx_dir = 1'b1; push_tx(d, 1'b1);
    tx_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(1'b1);
      if (i > 0) check("b2b_spacing", cyc - gc_prev, W + 1);
      gc_prev = cyc;
      if (i < 2) begin
        d = W'($urandom); tx_data = d; tx_dir = 1'($urandom); push_tx(d, tx_dir);
      end
    end
    tx_req = 1'b0;
    wait_idle();

    // RX requested mid-TX: granted only when TX finishes.
    do_tx(W'($urandom), 1'($urandom));
    gc_prev = cyc;
    repeat (2) @(negedge clk);
    do_rx(W'($urandom), 1'($urandom));
    check("mid_req_gnt_delay", cyc - gc_prev, W + 1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom % 2 == 1) do_tx(W'($urandom), 1'($urandom));
      else                   do_rx(W'($urandom), 1'($urandom));
      if ($urandom % 4 == 0) wait_idle();
      else repeat ($urandom % 3) @(negedge clk);
    end
    wait_idle();

    // Reset in the middle of a TX shift.
    do_rx(4'b1010, 1'b0);
    wait_idle();
    check("rx_before_rst", 32'(rx_data), 32'(4'b1010));
    do_tx(W'($urandom), 1'b1);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("usr_rst_n_in_rst", 32'(usr_rst_n), 0);
    @(negedge clk);
    check("usr_rst_n_in_rst2", 32'(usr_rst_n), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pmode", 32'(usr_pmode), 1);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    check("mid_rst_valid", 32'({tx_done, ser_out_valid}), 0);
    rst = 1'b0;
    tx_q.delete();
    active = 1'b0;
    mon_en = 1'b1;
    kind = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (tx_done) kind = 1'b1;
    end
    check("no_done_after_rst", 32'(kind), 0);

    // First tie after reset goes to TX.
    d = W'($urandom); tx_data = d; tx_dir = 1'b0; push_tx(d, 1'b0);
    push_rx(W'($urandom), 1'b1); rx_dir = 1'b1;
    tx_req = 1'b1; rx_req = 1'b1;
    wait_any(kind);
    check("tie_after_rst_tx", 32'(kind), 1);
    tx_req = 1'b0;
    wait_any(kind);
    check("tie_after_rst_rx", 32'(kind), 0);
    rx_req = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
